program_loader: RTL and testbench

- Writer-side master for the instruction memory write/read port.
- Accepts a byte stream through a valid/ready handshake, packs bytes into 16-bit instruction words, and writes them to consecutive instruction-memory addresses from 0.
- After the last write, reads every written word back through the same port and checks an XOR checksum.
- Sits between the host/UART byte source and instruction_mem; the CPU is held off while busy=1.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/byte_packer.sv | 37 +++
 rtl/program_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_program_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and error codes.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    VERIFY,
    DRAIN,
    CHECK,
    FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
  localparam logic [1:0] ERR_TOO_LONG = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/byte_packer.sv
// Two-byte to 16-bit word assembler, high byte first. The word is presented
// combinationally in the cycle the low byte transfers, so the owner can act
// on it in the same cycle (used for both the length field and payload words).
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic        i_ready,
  input  logic [7:0]  i_byte,
  output logic        o_valid,
  output logic [15:0] o_word
);

  logic       w_xfer;
  logic       r_phase;
  logic [7:0] r_hi;

  assign w_xfer  = i_valid & i_ready;
  assign o_valid = w_xfer & r_phase;
  assign o_word  = {r_hi, i_byte};

  // Latch the high byte and toggle the hi/lo phase on every accepted byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
    end else if (i_clear) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
    end else if (w_xfer) begin
      if (!r_phase) r_hi <= i_byte;
      r_phase <= ~r_phase;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the packed
// words to instruction memory from address 0, then reads them all back and
// compares XOR checksums. All outputs are registered.
//
// state   | meaning
// IDLE    | waiting for start, no bytes accepted
// LEN_HI  | accepting length high byte
// LEN_LO  | accepting length low byte, range check
// DATA_HI | accepting payload word high byte
// DATA_LO | accepting payload word low byte
// WRITE   | single write cycle to memory
// VERIFY  | issuing read addresses 0..N-1
// DRAIN   | collecting the last read word
// CHECK   | comparing checksums, reporting result
// FAIL    | reporting a length error
module program_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we_im,
  output logic [ADDR_W-1:0] add_im,
  output logic [15:0]       data_im_in,
  input  logic [15:0]       out_im,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  import loader_pkg::*;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t r_state, w_state_nxt;

  // r_addr counts writes during loading and doubles as "next read address"
  // during verify, so r_addr==1 in VERIFY marks the first issue cycle.
  logic [15:0]       r_len, w_len_nxt;
  logic [15:0]       r_addr, w_addr_nxt;
  logic [15:0]       r_wsum, w_wsum_nxt;
  logic [15:0]       r_rsum, w_rsum_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_add, w_add_nxt;
  logic [15:0]       r_data, w_data_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [1:0]        r_err, w_err_nxt;

  logic              w_xfer;
  logic              w_clear;
  logic              w_pk_valid;
  logic [15:0]       w_pk_word;

  assign w_xfer  = byte_valid & r_ready;
  assign w_clear = (r_state == IDLE) & start;

  byte_packer u_packer (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (w_clear),
    .i_valid (byte_valid),
    .i_ready (r_ready),
    .i_byte  (byte_in),
    .o_valid (w_pk_valid),
    .o_word  (w_pk_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, datapath and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_wsum_nxt  = r_wsum;
    w_rsum_nxt  = r_rsum;
    w_we_nxt    = 1'b0;
    w_add_nxt   = r_add;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_err_nxt   = ERR_NONE;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_xfer) w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (w_pk_valid) begin
          w_len_nxt = w_pk_word;
          if (w_pk_word == 16'd0 || w_pk_word > MAX_N) begin
            w_ready_nxt = 1'b0;
            w_state_nxt = FAIL;
          end else begin
            w_addr_nxt  = 16'd0;
            w_wsum_nxt  = 16'd0;
            w_state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (w_xfer) w_state_nxt = DATA_LO;
      end
      DATA_LO: begin
        if (w_pk_valid) begin
          w_ready_nxt = 1'b0;
          w_we_nxt    = 1'b1;
          w_add_nxt   = r_addr[ADDR_W-1:0];
          w_data_nxt  = w_pk_word;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_wsum_nxt = r_wsum ^ r_data;
        if (r_addr + 16'd1 == r_len) begin
          w_addr_nxt  = 16'd1;
          w_add_nxt   = '0;
          w_rsum_nxt  = 16'd0;
          w_state_nxt = VERIFY;
        end else begin
          w_addr_nxt  = r_addr + 16'd1;
          w_ready_nxt = 1'b1;
          w_state_nxt = DATA_HI;
        end
      end
      VERIFY: begin
        if (r_addr != 16'd1) w_rsum_nxt = r_rsum ^ out_im;
        if (r_addr == r_len) begin
          w_state_nxt = DRAIN;
        end else begin
          w_add_nxt  = r_addr[ADDR_W-1:0];
          w_addr_nxt = r_addr + 16'd1;
        end
      end
      DRAIN: begin
        w_rsum_nxt  = r_rsum ^ out_im;
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (r_rsum == r_wsum) begin
          w_done_nxt = 1'b1;
        end else begin
          w_error_nxt = 1'b1;
          w_err_nxt   = ERR_CHECKSUM;
        end
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      FAIL: begin
        w_error_nxt = 1'b1;
        w_err_nxt   = (r_len == 16'd0) ? ERR_ZERO_LEN : ERR_TOO_LONG;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers; reset drops we_im immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= 16'd0;
      r_addr  <= 16'd0;
      r_wsum  <= 16'd0;
      r_rsum  <= 16'd0;
      r_we    <= 1'b0;
      r_add   <= '0;
      r_data  <= 16'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_err   <= ERR_NONE;
    end else begin
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_wsum  <= w_wsum_nxt;
      r_rsum  <= w_rsum_nxt;
      r_we    <= w_we_nxt;
      r_add   <= w_add_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign byte_ready = r_ready;
  assign we_im      = r_we;
  assign add_im     = r_add;
  assign data_im_in = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader with an instruction memory model.
module tb_program_loader;

  localparam int ADDR_W    = 12;
  localparam int MAX_WORDS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we_im;
  logic [ADDR_W-1:0] add_im;
  logic [15:0]       data_im_in;
  logic [15:0]       out_im;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we_im      (we_im),
    .add_im     (add_im),
    .data_im_in (data_im_in),
    .out_im     (out_im),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  // instruction memory model: synchronous write, registered read, optional corrupted location
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic              corrupt_en;
  logic [ADDR_W-1:0] corrupt_addr;
  logic [15:0]       corrupt_val;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
    out_im = 16'h0000;
  end

  always @(posedge clk) begin
    if (we_im) mem[add_im] <= data_im_in;
    out_im <= (corrupt_en && add_im == corrupt_addr) ? corrupt_val : mem[add_im];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  typedef struct {
    int       n;
    bit       legal;
    bit       done;
    bit       error;
    logic [1:0] code;
    int       xfers;
    int       tail;
  } res_t;

  wr_t  exp_wr_q[$];
  res_t exp_res_q[$];
  logic [15:0] stim_w[$];

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // monitor: pops expected writes and session results as the DUT presents them
  bit   prev_busy;
  int   sess_xfer;
  int   tail;
  int   idle_xfer = 0;
  wr_t  mon_w;
  res_t mon_r;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      sess_xfer = 0;
      tail = 0;
    end else begin
      if (busy && !prev_busy) begin
        sess_xfer = 0;
        tail = 0;
        check("start_clear", {done, error, err_code}, 0);
      end
      if (byte_valid && byte_ready) begin
        if (busy) sess_xfer++;
        else      idle_xfer++;
      end
      if (we_im) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", add_im, mon_w.addr);
          check("wr_data", data_im_in, mon_w.data);
        end
        tail = 0;
      end else if (busy && !byte_ready) begin
        if (exp_res_q.size() > 0 && exp_res_q[0].legal && tail < exp_res_q[0].n)
          check("rd_addr", add_im, tail);
        tail++;
      end
      if (!busy && prev_busy) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          mon_r = exp_res_q.pop_front();
          check("done", done, mon_r.done);
          check("error", error, mon_r.error);
          check("err_code", err_code, mon_r.code);
          check("byte_xfers", sess_xfer, mon_r.xfers);
          check("tail_cycles", tail, mon_r.tail);
          check("pending_writes", exp_wr_q.size(), 0);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int bound;
    while (gap > 0 && $urandom_range(99) < gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in = b;
    bound = 0;
    while (!byte_ready && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    check("byte_ready_wait", byte_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int bound;
    bound = 0;
    while (busy && bound < 500) begin
      @(negedge clk);
      bound++;
    end
    check("session_end", busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // reference model: derive expected writes and outcome from the stream contents
  task automatic run_session(input int n, input int gap, input bit start_mid);
    res_t        r;
    wr_t         w;
    logic [15:0] x, rx, nf;
    nf = 16'(n);
    r.n = n;
    r.legal = (n >= 1 && n <= MAX_WORDS);
    x = 16'h0;
    rx = 16'h0;
    if (r.legal) begin
      for (int i = 0; i < n; i++) begin
        w.addr = ADDR_W'(i);
        w.data = stim_w[i];
        exp_wr_q.push_back(w);
        x ^= stim_w[i];
        rx ^= (corrupt_en && int'(corrupt_addr) == i) ? corrupt_val : stim_w[i];
      end
    end
    r.done  = r.legal && (x == rx);
    r.error = !r.done;
    r.code  = (n == 0) ? 2'd1 : (!r.legal) ? 2'd2 : r.done ? 2'd0 : 2'd3;
    r.xfers = r.legal ? 2 + 2 * n : 2;
    r.tail  = r.legal ? n + 2 : 1;
    exp_res_q.push_back(r);

    pulse_start();
    send_byte(nf[15:8], gap);
    send_byte(nf[7:0], gap);
    if (r.legal) begin
      for (int i = 0; i < n; i++) begin
        nf = stim_w[i];
        send_byte(nf[15:8], gap);
        send_byte(nf[7:0], gap);
      end
    end
    byte_valid = 1'b1;
    byte_in = 8'($urandom);
    if (start_mid) pulse_start();
    wait_idle();
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    corrupt_en = 1'b0;
    corrupt_addr = '0;
    corrupt_val = 16'h0;

    repeat (2) @(negedge clk);
    check("rst_ctrl", {we_im, byte_ready, busy, done, error, err_code}, 0);
    check("rst_add", add_im, 0);
    check("rst_data", data_im_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // bytes offered while idle must not be taken
    byte_valid = 1'b1;
    byte_in = 8'h55;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);

    stim_w = '{16'h1234, 16'hABCD, 16'h0F0F};
    run_session(3, 0, 1'b1);

    stim_w.delete();
    run_session(0, 0, 1'b0);
    run_session(17, 0, 1'b0);

    corrupt_en = 1'b1;
    corrupt_addr = ADDR_W'(1);
    corrupt_val = 16'hABCC;
    stim_w = '{16'h1234, 16'hABCD};
    run_session(2, 0, 1'b0);
    corrupt_en = 1'b0;

    stim_w.delete();
    for (int i = 0; i < 16; i++) stim_w.push_back(16'($urandom));
    run_session(16, 50, 1'b0);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, MAX_WORDS);
      stim_w.delete();
      for (int i = 0; i < n; i++) stim_w.push_back(16'($urandom));
      run_session(n, $urandom_range(0, 60), 1'b0);
    end

    // abort a session in DATA_LO of word 2 with reset
    stim_w.delete();
    for (int i = 0; i < 3; i++) stim_w.push_back(16'($urandom));
    for (int i = 0; i < 2; i++) begin
      mon_w.addr = ADDR_W'(i);
      mon_w.data = stim_w[i];
      exp_wr_q.push_back(mon_w);
    end
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(stim_w[0][15:8], 0);
    send_byte(stim_w[0][7:0], 0);
    send_byte(stim_w[1][15:8], 0);
    send_byte(stim_w[1][7:0], 0);
    send_byte(stim_w[2][15:8], 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ready", byte_ready, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_we_async", we_im, 0);
    check("rst_busy_async", busy, 0);
    check("rst_ready_async", byte_ready, 0);
    check("abort_writes", exp_wr_q.size(), 0);
    exp_wr_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    stim_w = '{16'h00FF};
    run_session(1, 0, 1'b0);
    check("mem_after_reload", mem[0], 16'h00FF);

    check("idle_xfer", idle_xfer, 0);
    check("queues_empty", exp_wr_q.size() + exp_res_q.size(), 0);
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
